alu_op_sequencer: RTL and testbench

//  Control FSM for the 32-bit ALUCell array in the RV32EC execute stage. Accepts one ALU op per

---
 rtl/rv_alu_pkg.sv | 35 +++
 rtl/alu_ctl_decode.sv | 20 ++
 rtl/alu_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared types for the RV32EC ALU sequencer: op codes, array control word, FSM states.
package rv_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_e;

    // Field order matches the array's control pins, cin is the LSB carry-in.
    typedef struct packed {
        logic orSel;
        logic invA;
        logic invB;
        logic flood;
        logic cin;
    } alu_ctl_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

    localparam alu_ctl_t ALU_CTL_IDLE = '0;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational op -> array control word; zero latency, no flow control.
module alu_ctl_decode
    import rv_alu_pkg::*;
(
    input  alu_op_e  op,
    output alu_ctl_t ctl
);

    // AND is De Morgan on the OR path: ~(~a | ~b), with flood inverting the output.
    always_comb begin
        ctl = ALU_CTL_IDLE;
        case (op)
            OP_SUB, OP_SLT, OP_SLTU: ctl = '{orSel: 1'b0, invA: 1'b0, invB: 1'b1, flood: 1'b0, cin: 1'b1};
            OP_OR:                   ctl = '{orSel: 1'b1, invA: 1'b0, invB: 1'b0, flood: 1'b0, cin: 1'b0};
            OP_AND:                  ctl = '{orSel: 1'b1, invA: 1'b1, invB: 1'b1, flood: 1'b1, cin: 1'b0};
            default:                 ctl = ALU_CTL_IDLE;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU array sequencer: 1 cycle for array ops, one step per cycle for shifts; result held until rsp_ready.
// ALU_SEQ_SHIFT4_EN: shifts step by 4 while possible and are all done internally.
module alu_op_sequencer
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_ctl,
    input  logic [XLEN-1:0] alu_c,
    input  logic            alu_cout
);

    localparam int SHW = $clog2(XLEN);

    seq_state_e      state;
    alu_op_e         opReg;
    alu_ctl_t        ctlReg;
    alu_ctl_t        decCtl;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  cnt;

    alu_op_e         reqOp;
    logic [SHW-1:0]  reqShamt;
    logic            reqIsShift;
    logic            accept;
    logic            ovf;
    logic [XLEN-1:0] execResult;
    logic [SHW-1:0]  stepBy;
    logic [XLEN-1:0] stepped;

    assign reqOp      = alu_op_e'(req_op);
    assign reqShamt   = req_b[SHW-1:0];
    assign reqIsShift = reqOp inside {OP_SLL, OP_SRL, OP_SRA};

    alu_ctl_decode uCtlDecode (
        .op  (reqOp),
        .ctl (decCtl)
    );

    assign req_ready = !flush && (state == S_IDLE || (state == S_DONE && rsp_ready));
    assign rsp_valid = (state == S_DONE);
    assign accept    = req_valid && req_ready;
    assign alu_ctl   = ctlReg;

    // alu_a/alu_b still hold the latched operands during EXEC.
    always_comb begin
        ovf = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_c[XLEN-1] != alu_a[XLEN-1]);
        case (opReg)
            OP_XOR:  execResult = alu_a ^ alu_b;
            OP_SLT:  execResult = {{(XLEN-1){1'b0}}, alu_c[XLEN-1] ^ ovf};
            OP_SLTU: execResult = {{(XLEN-1){1'b0}}, ~alu_cout};
            default: execResult = alu_c;
        endcase
    end

`ifdef ALU_SEQ_SHIFT4_EN
    assign stepBy = (cnt >= SHW'(4)) ? SHW'(4) : SHW'(1);

    always_comb begin
        case (opReg)
            OP_SLL:  stepped = acc << stepBy;
            OP_SRA:  stepped = $signed(acc) >>> stepBy;
            default: stepped = acc >> stepBy;
        endcase
    end
`else
    assign stepBy = SHW'(1);

    // SLL doubles through the array: alu_a = alu_b = acc with the ADD control word.
    always_comb begin
        case (opReg)
            OP_SLL:  stepped = alu_c;
            OP_SRA:  stepped = {acc[XLEN-1], acc[XLEN-1:1]};
            default: stepped = {1'b0, acc[XLEN-1:1]};
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            opReg      <= OP_ADD;
            ctlReg     <= ALU_CTL_IDLE;
            acc        <= '0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
        end else if (flush) begin
            state  <= S_IDLE;
            ctlReg <= ALU_CTL_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        opReg <= reqOp;
                        acc   <= req_a;
                        cnt   <= reqShamt;
                        if (!reqIsShift) begin
                            state  <= S_EXEC;
                            ctlReg <= decCtl;
                            alu_a  <= req_a;
                            alu_b  <= req_b;
                        end else begin
                            // A zero shift still spends one SHIFT cycle so latency is never 0.
                            state <= S_SHIFT;
`ifndef ALU_SEQ_SHIFT4_EN
                            if (reqOp == OP_SLL && reqShamt != '0) begin
                                ctlReg <= decCtl;
                                alu_a  <= req_a;
                                alu_b  <= req_a;
                            end
`endif
                        end
                    end else if (state == S_DONE && rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    rsp_result <= execResult;
                    ctlReg     <= ALU_CTL_IDLE;
                    state      <= S_DONE;
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
                        rsp_result <= acc;
                        state      <= S_DONE;
                    end else begin
                        acc <= stepped;
                        cnt <= cnt - stepBy;
`ifndef ALU_SEQ_SHIFT4_EN
                        if (opReg == OP_SLL) begin
                            alu_a <= stepped;
                            alu_b <= stepped;
                        end
`endif
                        if (cnt == stepBy) begin
                            rsp_result <= stepped;
                            ctlReg     <= ALU_CTL_IDLE;
                            state      <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALUCell array and an arithmetic reference model.
module tb_alu_op_sequencer;
    import rv_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctl;
    logic [31:0] alu_c;
    logic        alu_cout;

    int tests = 0;
    int fails = 0;

`ifdef ALU_SEQ_SHIFT4_EN
    localparam int LAT_SH4  = 1;
    localparam int LAT_SH31 = 10;
    localparam int FLUSH_AT = 5;
`else
    localparam int LAT_SH4  = 4;
    localparam int LAT_SH31 = 31;
    localparam int FLUSH_AT = 10;
`endif

    alu_op_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_c      (alu_c),
        .alu_cout   (alu_cout)
    );

    always #5 clk = ~clk;

    // ALUCell array: optional operand inversion, OR or ripple-add, optional output inversion.
    logic [31:0] arrT, arrU, arrR;
    logic [32:0] arrS;
    always_comb begin
        arrT     = alu_ctl[3] ? ~alu_a : alu_a;
        arrU     = alu_ctl[2] ? ~alu_b : alu_b;
        arrS     = {1'b0, arrT} + {1'b0, arrU} + {32'b0, alu_ctl[0]};
        arrR     = alu_ctl[4] ? (arrT | arrU) : arrS[31:0];
        alu_c    = alu_ctl[1] ? ~arrR : arrR;
        alu_cout = arrS[32];
    end

    function automatic logic [31:0] refResult(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {31'b0, ($signed(a) < $signed(b))};
            OP_SLTU: return {31'b0, (a < b)};
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            default: return $signed(a) >>> b[4:0];
        endcase
    endfunction

    function automatic int refLat(input alu_op_e op, input logic [31:0] b);
        int sh;
        int n;
        if (!(op inside {OP_SLL, OP_SRL, OP_SRA})) return 1;
        sh = int'(b[4:0]);
`ifdef ALU_SEQ_SHIFT4_EN
        n = sh / 4 + sh % 4;
`else
        n = sh;
`endif
        return (n < 1) ? 1 : n;
    endfunction

    // Issue one request, measure accept-edge -> rsp_valid latency, then consume the response.
    task automatic runOp(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output logic [4:0] ctlExec, output logic [4:0] ctlDone, output bit ok);
        int w;
        ok = 1'b0;
        lat = 0;
        res = '0;
        ctlExec = '0;
        ctlDone = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        rsp_ready = 1'b0;
        #1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ctlExec = alu_ctl;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!ok) return;
        res = rsp_result;
        ctlDone = alu_ctl;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_result !== 32'h0) begin fails++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
        tests++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin fails++; $display("FAIL reset_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
        tests++; if (alu_ctl !== 5'h0) begin fails++; $display("FAIL reset_alu_ctl: got %b want 00000", alu_ctl); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        logic [4:0]  ctl;
    } dvec_t;

    task automatic test_directed();
        dvec_t vec[11];
        logic [31:0] res;
        int lat;
        logic [4:0] ctlExec, ctlDone;
        bit ok;
        vec[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h1,    32'h80000000, 1,        5'b00000};
        vec[1]  = '{OP_SUB,  32'h5,        32'h7,    32'hFFFFFFFE, 1,        5'b00101};
        vec[2]  = '{OP_SLT,  32'h80000000, 32'h1,    32'h1,        1,        5'b00101};
        vec[3]  = '{OP_SLTU, 32'h80000000, 32'h1,    32'h0,        1,        5'b00101};
        vec[4]  = '{OP_AND,  32'hF0F0,     32'h0FF0, 32'h00F0,     1,        5'b11110};
        vec[5]  = '{OP_OR,   32'hF0F0,     32'h0FF0, 32'hFFF0,     1,        5'b10000};
        vec[6]  = '{OP_XOR,  32'hF0F0,     32'h0FF0, 32'hFF00,     1,        5'b00000};
        vec[7]  = '{OP_SRA,  32'h80000010, 32'h4,    32'hF8000001, LAT_SH4,  5'b00000};
        vec[8]  = '{OP_SLL,  32'h12345678, 32'h0,    32'h12345678, 1,        5'b00000};
        vec[9]  = '{OP_SLL,  32'h1,        32'h1F,   32'h80000000, LAT_SH31, 5'b00000};
        vec[10] = '{OP_SRL,  32'h80000000, 32'h1F,   32'h1,        LAT_SH31, 5'b00000};
        foreach (vec[i]) begin
            runOp(vec[i].op, vec[i].a, vec[i].b, res, lat, ctlExec, ctlDone, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL dir_%s_timeout: no response within cycle budget", vec[i].op.name());
            end else begin
                tests++; if (res !== vec[i].res) begin fails++; $display("FAIL dir_%s_result: got %h want %h", vec[i].op.name(), res, vec[i].res); end
                tests++; if (lat !== vec[i].lat) begin fails++; $display("FAIL dir_%s_latency: got %0d want %0d", vec[i].op.name(), lat, vec[i].lat); end
                tests++; if (ctlExec !== vec[i].ctl) begin fails++; $display("FAIL dir_%s_ctl: got %b want %b", vec[i].op.name(), ctlExec, vec[i].ctl); end
                tests++; if (ctlDone !== 5'b0) begin fails++; $display("FAIL dir_%s_ctl_done: got %b want 00000", vec[i].op.name(), ctlDone); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, exp1, exp2;
        int n;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        exp1 = a1 ^ b1;
        exp2 = a2 + b2;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_XOR; req_a = a1; req_b = b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_first_rsp: got rsp_valid %b want 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_hold_valid[%0d]: got %b want 1", i, rsp_valid); end
            tests++; if (rsp_result !== exp1) begin fails++; $display("FAIL b2b_hold_result[%0d]: got %h want %h", i, rsp_result, exp1); end
            @(negedge clk);
        end
        rsp_ready = 1'b1; req_valid = 1'b1; req_op = OP_ADD; req_a = a2; req_b = b2;
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_req_ready: got %b want 1", req_ready); end
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_duplicate: got rsp_valid %b want 0", rsp_valid); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_second_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_result !== exp2) begin fails++; $display("FAIL b2b_second_result: got %h want %h", rsp_result, exp2); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SLL; req_a = $urandom | 32'h1; req_b = 32'h1F; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (FLUSH_AT - 1) @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_pre_valid: got %b want 0", rsp_valid); end
        flush = 1'b1; req_valid = 1'b1; req_op = OP_ADD; req_a = 32'h1; req_b = 32'h2;
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_req_ready: got %b want 0", req_ready); end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL flush_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL flush_idle_ready: got %b want 1", req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_response: got rsp_valid seen %b want 0", seen); end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SUB; req_a = 32'h11111111; req_b = 32'h22222222;
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (alu_ctl !== 5'b00101) begin fails++; $display("FAIL rstmid_exec_ctl: got %b want 00101", alu_ctl); end
        rst_n = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_handshake: got ready %b valid %b want 1 0", req_ready, rsp_valid); end
        tests++; if (alu_ctl !== 5'b0) begin fails++; $display("FAIL rstmid_ctl: got %b want 00000", alu_ctl); end
        tests++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin fails++; $display("FAIL rstmid_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
        tests++; if (rsp_result !== 32'h0) begin fails++; $display("FAIL rstmid_result: got %h want 0", rsp_result); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_op_lost: got rsp_valid %b want 0", rsp_valid); end
    endtask

    task automatic test_random();
        alu_op_e opList[10] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};
        alu_op_e op;
        logic [31:0] a, b, res, expRes;
        int lat, expLat;
        logic [4:0] ctlExec, ctlDone;
        bit ok;
        for (int i = 0; i < 60; i++) begin
            op = opList[$urandom_range(0, 9)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: a = 32'h80000000;
                1: b = 32'h7FFFFFFF;
                2: b = a;
                default: ;
            endcase
            expRes = refResult(op, a, b);
            expLat = refLat(op, b);
            runOp(op, a, b, res, lat, ctlExec, ctlDone, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL rand[%0d]_%s_timeout: no response within cycle budget", i, op.name());
            end else begin
                tests++; if (res !== expRes) begin fails++; $display("FAIL rand[%0d]_%s_result: a=%h b=%h got %h want %h", i, op.name(), a, b, res, expRes); end
                tests++; if (lat !== expLat) begin fails++; $display("FAIL rand[%0d]_%s_latency: got %0d want %0d", i, op.name(), lat, expLat); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
